ntt_butterfly_ct: RTL and testbench

//  Pipelined Cooley-Tukey NTT butterfly for NewHope, modulus q = 12289.
//  Per accepted sample computes t = b*w mod q, x = (a + t) mod q, y = (a - t) mod q.

---
 rtl/newhope_pkg.sv | 19 +
 rtl/ntt_butterfly_ct_if.sv | 15 +
 rtl/modq_mul_barrett.sv | 57 +++++
 rtl/ntt_butterfly_ct.sv | 69 ++++++
 tb/tb_ntt_butterfly_ct.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/newhope_pkg.sv
// Shared NewHope arithmetic constants and the coefficient type used by the NTT datapath.
package newhope_pkg;

  localparam int unsigned NH_Q       = 12289;
  localparam int unsigned NH_BARR_M  = 21843;
  localparam int unsigned NH_BARR_K  = 28;
  localparam int unsigned NH_COEFF_W = 16;

  typedef logic [NH_COEFF_W-1:0] coeff_t;

  localparam coeff_t Q_C  = coeff_t'(NH_Q);
  localparam coeff_t Q2_C = coeff_t'(2 * NH_Q);

  // Maps a value in 0..2Q-1 onto 0..Q-1.
  function automatic coeff_t cond_sub_q(input coeff_t v);
    return (v >= Q_C) ? coeff_t'(v - Q_C) : v;
  endfunction

endpackage

// File: rtl/ntt_butterfly_ct_if.sv
// Sample-in / result-out bundle of the Cooley-Tukey butterfly.
interface ntt_butterfly_ct_if;
  import newhope_pkg::*;

  logic   in_valid;
  coeff_t a;
  coeff_t b;
  coeff_t w;
  logic   out_valid;
  coeff_t x;
  coeff_t y;

  modport master (output in_valid, a, b, w, input out_valid, x, y);
  modport slave  (input in_valid, a, b, w, output out_valid, x, y);
endinterface

// File: rtl/modq_mul_barrett.sv
// Five-stage b*w mod Q with Barrett reduction, clock enable and valid passthrough.
module modq_mul_barrett
  import newhope_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clken,
  input  logic   in_valid_i,
  input  coeff_t b_i,
  input  coeff_t w_i,
  output logic   out_valid_o,
  output coeff_t t_o
);

  logic [4:0]  v_q;
  coeff_t      b_q, w_q;
  logic [27:0] p2_q, p3_q, p_d;
  logic [14:0] e3_q, e_d;
  coeff_t      r4_q, r_d;
  coeff_t      t5_q, t_d;

  always_comb begin
    p_d = {12'd0, b_q} * {12'd0, w_q};
    // e never exceeds p/Q, so the top 15 bits of the 43-bit product are all that survive.
    e_d = 15'(({15'd0, p2_q} * 43'(NH_BARR_M)) >> NH_BARR_K);
    r_d = coeff_t'(p3_q - {13'd0, e3_q} * 28'(NH_Q));
    t_d = (r4_q >= Q2_C) ? coeff_t'(r4_q - Q2_C) : cond_sub_q(r4_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of the stage before it, whatever order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      b_q  <= '0;
      w_q  <= '0;
      p2_q <= '0;
      p3_q <= '0;
      e3_q <= '0;
      r4_q <= '0;
      t5_q <= '0;
    end else if (clken) begin
      v_q  <= {v_q[3:0], in_valid_i};
      b_q  <= b_i;
      w_q  <= w_i;
      p2_q <= p_d;
      p3_q <= p2_q;
      e3_q <= e_d;
      r4_q <= r_d;
      t5_q <= t_d;
    end
  end

  assign out_valid_o = v_q[4];
  assign t_o         = t5_q;

endmodule

// File: rtl/ntt_butterfly_ct.sv
// NewHope Cooley-Tukey butterfly: x = a + b*w, y = a - b*w (mod Q), six enabled cycles deep.
module ntt_butterfly_ct
  import newhope_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clken,
  ntt_butterfly_ct_if.slave bus
);

  localparam int unsigned A_DEPTH = 5;

  coeff_t a_q [A_DEPTH];
  coeff_t t;
  logic   t_valid;
  coeff_t s_d, d_d, x_d, y_d;
  coeff_t x_q, y_q;
  logic   out_valid_q;

  modq_mul_barrett u_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .clken       (clken),
    .in_valid_i  (bus.in_valid),
    .b_i         (bus.b),
    .w_i         (bus.w),
    .out_valid_o (t_valid),
    .t_o         (t)
  );

  // NOTE: the delay line is a register array, so it gets an explicit reset loop; an array
  // left out of the reset branch would let stale data reach x/y after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < A_DEPTH; i++) a_q[i] <= '0;
    end else if (clken) begin
      a_q[0] <= bus.a;
      for (int i = 1; i < A_DEPTH; i++) a_q[i] <= a_q[i-1];
    end
  end

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    s_d = coeff_t'(a_q[A_DEPTH-1] + t);
    d_d = coeff_t'(a_q[A_DEPTH-1] - t + Q_C);
    x_d = cond_sub_q(s_d);
    y_d = cond_sub_q(d_d);
  end

  // x/y only load on a valid result so they keep the last one across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else if (clken) begin
      out_valid_q <= t_valid;
      if (t_valid) begin
        x_q <= x_d;
        y_q <= y_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;

endmodule

// File: tb/tb_ntt_butterfly_ct.sv
// Directed bench for ntt_butterfly_ct: reset, latency, boundaries, streaming, stalls, exhaustive b.
module tb_ntt_butterfly_ct;

  localparam int Q = 12289;
  localparam int N = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic clken;

  ntt_butterfly_ct_if bus ();

  ntt_butterfly_ct dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clken (clken),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int freeze_err = 0;

  logic [15:0] got_x [$];
  logic [15:0] got_y [$];
  logic [15:0] stim_a [N];
  logic [15:0] stim_b [N];
  logic [15:0] stim_w [N];
  logic [15:0] exp_x [N];
  logic [15:0] exp_y [N];

  function automatic logic [15:0] ref_x(input int a, input int b, input int w);
    int t;
    t = (b * w) % Q;
    return 16'((a + t) % Q);
  endfunction

  function automatic logic [15:0] ref_y(input int a, input int b, input int w);
    int t;
    t = (b * w) % Q;
    return 16'((a - t + Q) % Q);
  endfunction

  // One clock: drive at negedge, pass a posedge, observe at the following negedge.
  task automatic step(input logic en, input logic v,
                      input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] iw);
    logic ov;
    logic [15:0] ox, oy;
    ov = bus.out_valid;
    ox = bus.x;
    oy = bus.y;
    clken = en;
    bus.in_valid = v;
    bus.a = ia;
    bus.b = ib;
    bus.w = iw;
    @(posedge clk);
    @(negedge clk);
    if (!en && (bus.out_valid !== ov || bus.x !== ox || bus.y !== oy)) freeze_err++;
    if (en && bus.out_valid === 1'b1) begin
      got_x.push_back(bus.x);
      got_y.push_back(bus.y);
    end
  endtask

  task automatic clear_q();
    got_x.delete();
    got_y.delete();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
  endtask

  task automatic test_reset();
    clken = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = 16'd0;
    bus.b = 16'd0;
    bus.w = 16'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    clken = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'd5;
    bus.b = 16'd7;
    bus.w = 16'd9;
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %0d want 0", k, bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.x !== 16'd0) $display("FAIL reset_x[%0d]: got %0d want 0", k, bus.x);
      else pass_cnt++;
      total_cnt++;
      if (bus.y !== 16'd0) $display("FAIL reset_y[%0d]: got %0d want 0", k, bus.y);
      else pass_cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int first;
    clear_q();
    first = -1;
    step(1'b1, 1'b1, 16'd1, 16'd2, 16'd3);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
      if (first < 0 && got_x.size() > 0) first = i;
    end
    total_cnt++;
    if (first !== 5) $display("FAIL single_latency: got %0d want 5", first);
    else pass_cnt++;
    total_cnt++;
    if (got_x.size() !== 1) $display("FAIL single_count: got %0d want 1", got_x.size());
    else pass_cnt++;
    if (got_x.size() > 0) begin
      total_cnt++;
      if (got_x[0] !== 16'd7) $display("FAIL single_x: got %0d want 7", got_x[0]);
      else pass_cnt++;
      total_cnt++;
      if (got_y[0] !== 16'd12284) $display("FAIL single_y: got %0d want 12284", got_y[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_boundary();
    // a, b, w, x, y
    int vec [3][5];
    vec[0] = '{0, 12288, 12288, 1, 12288};
    vec[1] = '{12288, 1, 12288, 12287, 0};
    vec[2] = '{0, 0, 5, 0, 0};
    clear_q();
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 16'(vec[i][0]), 16'(vec[i][1]), 16'(vec[i][2]));
    drain(8);
    total_cnt++;
    if (got_x.size() !== 3) $display("FAIL boundary_count: got %0d want 3", got_x.size());
    else pass_cnt++;
    for (int i = 0; i < 3 && i < got_x.size(); i++) begin
      total_cnt++;
      if (got_x[i] !== 16'(vec[i][3])) $display("FAIL boundary_x[%0d]: got %0d want %0d", i, got_x[i], vec[i][3]);
      else pass_cnt++;
      total_cnt++;
      if (got_y[i] !== 16'(vec[i][4])) $display("FAIL boundary_y[%0d]: got %0d want %0d", i, got_y[i], vec[i][4]);
      else pass_cnt++;
    end
  endtask

  task automatic compare_stream(input string tag);
    total_cnt++;
    if (got_x.size() !== N) $display("FAIL %s_count: got %0d want %0d", tag, got_x.size(), N);
    else pass_cnt++;
    for (int i = 0; i < N && i < got_x.size(); i++) begin
      total_cnt++;
      if (got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i])
        $display("FAIL %s_data[%0d]: got x=%0d y=%0d want x=%0d y=%0d",
                 tag, i, got_x[i], got_y[i], exp_x[i], exp_y[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int first, last, prev;
    for (int i = 0; i < N; i++) begin
      stim_a[i] = 16'($urandom_range(0, Q - 1));
      stim_b[i] = 16'($urandom_range(0, Q - 1));
      stim_w[i] = 16'($urandom_range(0, Q - 1));
      exp_x[i] = ref_x(int'(stim_a[i]), int'(stim_b[i]), int'(stim_w[i]));
      exp_y[i] = ref_y(int'(stim_a[i]), int'(stim_b[i]), int'(stim_w[i]));
    end
    clear_q();
    first = -1;
    last = -1;
    for (int i = 0; i < N + 8; i++) begin
      prev = got_x.size();
      if (i < N) step(1'b1, 1'b1, stim_a[i], stim_b[i], stim_w[i]);
      else step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
      if (got_x.size() > prev) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    total_cnt++;
    if (last - first !== N - 1) $display("FAIL b2b_contiguous: got span %0d want %0d", last - first, N - 1);
    else pass_cnt++;
    compare_stream("b2b");
  endtask

  task automatic test_stall();
    int idx, cyc;
    logic en;
    clear_q();
    freeze_err = 0;
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < 1000) begin
      en = (cyc >= 40 && cyc < 43) ? 1'b0 : ($urandom_range(0, 2) != 0);
      step(en, 1'b1, stim_a[idx], stim_b[idx], stim_w[idx]);
      if (en) idx++;
      cyc++;
    end
    drain(8);
    total_cnt++;
    if (idx !== N) $display("FAIL stall_accept: got %0d want %0d", idx, N);
    else pass_cnt++;
    total_cnt++;
    if (freeze_err !== 0) $display("FAIL stall_freeze: got %0d changes want 0", freeze_err);
    else pass_cnt++;
    compare_stream("stall");
  endtask

  task automatic test_reset_inflight();
    logic [15:0] pre_x;
    clear_q();
    pre_x = bus.x;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, stim_a[i], stim_b[i], stim_w[i]);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.x !== 16'd0 || bus.y !== 16'd0)
      $display("FAIL inflight_async_clear: got v=%0d x=%0d y=%0d (x before %0d) want 0 0 0",
               bus.out_valid, bus.x, bus.y, pre_x);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain(10);
    total_cnt++;
    if (got_x.size() !== 0) $display("FAIL inflight_lost: got %0d outputs want 0", got_x.size());
    else pass_cnt++;
    step(1'b1, 1'b1, 16'd1, 16'd2, 16'd3);
    drain(8);
    total_cnt++;
    if (got_x.size() !== 1 || got_x[0] !== 16'd7 || got_y[0] !== 16'd12284)
      $display("FAIL inflight_restart: got n=%0d x=%0d y=%0d want n=1 x=7 y=12284",
               got_x.size(), (got_x.size() > 0) ? got_x[0] : 16'd0, (got_y.size() > 0) ? got_y[0] : 16'd0);
    else pass_cnt++;
  endtask

  task automatic test_exhaustive();
    int errs_x, errs_y;
    clear_q();
    for (int b = 0; b < Q; b++) step(1'b1, 1'b1, 16'd0, 16'(b), 16'd12288);
    drain(8);
    total_cnt++;
    if (got_x.size() !== Q) $display("FAIL exh_count: got %0d want %0d", got_x.size(), Q);
    else pass_cnt++;
    errs_x = 0;
    errs_y = 0;
    for (int b = 0; b < Q && b < got_x.size(); b++) begin
      if (got_y[b] !== 16'(b)) errs_y++;
      if (got_x[b] !== 16'((Q - b) % Q)) errs_x++;
    end
    total_cnt++;
    if (errs_y !== 0) $display("FAIL exh_y: got %0d wrong y want 0", errs_y);
    else pass_cnt++;
    total_cnt++;
    if (errs_x !== 0) $display("FAIL exh_x: got %0d wrong x want 0", errs_x);
    else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
